// File: rtl/microwave_cook_ctrl_if.sv
// Control/status bundle between the microwave front panel and the cook sequencer.
interface microwave_cook_ctrl_if #(
    parameter int unsigned TIME_W = 10
);
    logic              start;
    logic              stop;
    logic              time_add;
    logic              door_open;
    logic [1:0]        mode;
    logic              idle;
    logic              cooking;
    logic              magnetron_en;
    logic              beep;
    logic [TIME_W-1:0] remaining;

    // Panel side: drives requests, observes status.
    modport master (
        output start, stop, time_add, door_open, mode,
        input  idle, cooking, magnetron_en, beep, remaining
    );

    // Sequencer side.
    modport slave (
        input  start, stop, time_add, door_open, mode,
        output idle, cooking, magnetron_en, beep, remaining
    );
endinterface

// File: rtl/microwave_cook_ctrl.sv
// Cook-cycle sequencer: time keeping, 1 s countdown, duty-cycled magnetron drive,
// door interlock, pause/resume/cancel and end-of-cook beep.
module microwave_cook_ctrl #(
    parameter int unsigned CLK_DIV  = 100000000,
    parameter int unsigned TIME_W   = 10,
    parameter int unsigned ADD_SEC  = 30,
    parameter int unsigned MAX_SEC  = 999,
    parameter int unsigned BEEP_SEC = 3
) (
    input logic                 clk,
    input logic                 rst,
    microwave_cook_ctrl_if.slave bus
);
    localparam int unsigned PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BEEP_W = (BEEP_SEC > 1) ? $clog2(BEEP_SEC + 1) : 1;
    localparam int unsigned WIN_W  = 4;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_DIV - 1);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_SEC - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(9);
    localparam logic [1:0]        MODE_LOW  = 2'b01;
    localparam logic [1:0]        MODE_NORM = 2'b10;
    localparam logic [1:0]        MODE_HIGH = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COOK  = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q;
    logic [TIME_W-1:0]   remaining_q;
    logic [PRE_W-1:0]    presc_q;
    logic [WIN_W-1:0]    win_q;
    logic [BEEP_W-1:0]   beep_cnt_q;
    logic [1:0]          mode_q;

    logic                tick_c;
    logic [TIME_W:0]     sum_c;
    logic [TIME_W-1:0]   added_c;
    logic [WIN_W-1:0]    on_win_c;
    logic                start_ok_c;

    // One-second tick: prescaler runs only while cooking or beeping.
    assign tick_c = ((state_q == S_COOK) || (state_q == S_DONE)) && (presc_q == PRE_LAST);

    // Saturating time_add, summed one bit wider so the overflow is visible.
    assign sum_c   = {1'b0, remaining_q} + (TIME_W+1)'(ADD_SEC);
    assign added_c = (sum_c > (TIME_W+1)'(MAX_SEC)) ? TIME_W'(MAX_SEC) : sum_c[TIME_W-1:0];

    assign start_ok_c = bus.start && !bus.door_open;

    // On-window length out of 10 s for the latched power mode (00 behaves as normal).
    always_comb begin
        on_win_c = WIN_W'(6);
        case (mode_q)
            MODE_LOW:  on_win_c = WIN_W'(3);
            MODE_NORM: on_win_c = WIN_W'(6);
            MODE_HIGH: on_win_c = WIN_W'(10);
            default:   on_win_c = WIN_W'(6);
        endcase
    end

    // Sequencer state, countdown, duty window and beep timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            presc_q     <= '0;
            win_q       <= '0;
            beep_cnt_q  <= '0;
            mode_q      <= MODE_NORM;
        end else begin
            if ((state_q == S_COOK) || (state_q == S_DONE)) begin
                presc_q <= tick_c ? '0 : presc_q + PRE_W'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (bus.stop) begin
                        remaining_q <= '0;
                    end else if (start_ok_c) begin
                        state_q <= S_COOK;
                        mode_q  <= bus.mode;
                        win_q   <= '0;
                        presc_q <= '0;
                        if (remaining_q == '0) begin
                            remaining_q <= TIME_W'(ADD_SEC);
                        end
                    end else if (bus.time_add) begin
                        remaining_q <= added_c;
                    end
                end
                S_COOK: begin
                    // Door or stop pre-empts a coincident tick, so that second is not lost.
                    if (bus.door_open || bus.stop) begin
                        state_q <= S_PAUSE;
                    end else if (tick_c) begin
                        remaining_q <= remaining_q - TIME_W'(1);
                        win_q       <= (win_q == WIN_LAST) ? '0 : win_q + WIN_W'(1);
                        if (remaining_q == TIME_W'(1)) begin
                            state_q    <= S_DONE;
                            beep_cnt_q <= '0;
                        end
                    end else if (bus.time_add) begin
                        remaining_q <= added_c;
                    end
                end
                S_PAUSE: begin
                    if (bus.stop) begin
                        state_q     <= S_IDLE;
                        remaining_q <= '0;
                    end else if (start_ok_c) begin
                        state_q <= S_COOK;
                    end else if (bus.time_add) begin
                        remaining_q <= added_c;
                    end
                end
                S_DONE: begin
                    if (bus.start || bus.stop) begin
                        state_q <= S_IDLE;
                    end else if (tick_c) begin
                        beep_cnt_q <= beep_cnt_q + BEEP_W'(1);
                        if (beep_cnt_q == BEEP_LAST) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Status decoded from state; magnetron drops combinationally on door open.
    assign bus.idle         = (state_q == S_IDLE);
    assign bus.cooking      = (state_q == S_COOK);
    assign bus.beep         = (state_q == S_DONE);
    assign bus.remaining    = remaining_q;
    assign bus.magnetron_en = (state_q == S_COOK) && !bus.door_open && (win_q < on_win_c);

endmodule

// File: tb/tb_microwave_cook_ctrl.sv
// Bench for microwave_cook_ctrl: directed scenarios plus random panel activity,
// all checked against a seconds-level behavioural model.
module tb_microwave_cook_ctrl;
    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned TIME_W   = 10;
    localparam int unsigned ADD_SEC  = 30;
    localparam int unsigned MAX_SEC  = 999;
    localparam int unsigned BEEP_SEC = 3;

    localparam int M_IDLE  = 0;
    localparam int M_COOK  = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    microwave_cook_ctrl_if #(.TIME_W(TIME_W)) bus ();

    microwave_cook_ctrl #(
        .CLK_DIV (CLK_DIV),
        .TIME_W  (TIME_W),
        .ADD_SEC (ADD_SEC),
        .MAX_SEC (MAX_SEC),
        .BEEP_SEC(BEEP_SEC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode of operation, seconds left, cycles into the
    // current second, seconds into the 10 s duty window, beep seconds elapsed.
    int m_st, m_rem, m_phase, m_win, m_beep, m_on;

    logic last_mag, last_beep;

    task automatic check_val(input string tag, input logic [31:0] obs, input int exp);
        n_vec++;
        if (obs !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int window_of(input logic [1:0] m);
        if (m == 2'b01) return 3;
        if (m == 2'b11) return 10;
        return 6;
    endfunction

    function automatic int sat_add(input int r);
        return (r + int'(ADD_SEC) > int'(MAX_SEC)) ? int'(MAX_SEC) : r + int'(ADD_SEC);
    endfunction

    function automatic void model_reset();
        m_st = M_IDLE; m_rem = 0; m_phase = 0; m_win = 0; m_beep = 0; m_on = 6;
    endfunction

    function automatic void model_step(input bit s, input bit sp, input bit a, input bit d,
                                       input logic [1:0] m);
        bit running;
        bit second_done;
        running     = (m_st == M_COOK) || (m_st == M_DONE);
        second_done = running && (m_phase == int'(CLK_DIV) - 1);
        if (running) m_phase = (m_phase + 1) % int'(CLK_DIV);
        case (m_st)
            M_IDLE: begin
                if (sp) m_rem = 0;
                else if (s && !d) begin
                    if (m_rem == 0) m_rem = ADD_SEC;
                    m_st = M_COOK; m_phase = 0; m_win = 0; m_on = window_of(m);
                end else if (a) m_rem = sat_add(m_rem);
            end
            M_COOK: begin
                if (d || sp) m_st = M_PAUSE;
                else if (second_done) begin
                    m_rem--;
                    m_win = (m_win + 1) % 10;
                    if (m_rem == 0) begin m_st = M_DONE; m_beep = 0; end
                end else if (a) m_rem = sat_add(m_rem);
            end
            M_PAUSE: begin
                if (sp) begin m_st = M_IDLE; m_rem = 0; end
                else if (s && !d) m_st = M_COOK;
                else if (a) m_rem = sat_add(m_rem);
            end
            default: begin
                if (s || sp) m_st = M_IDLE;
                else if (second_done) begin
                    m_beep++;
                    if (m_beep == int'(BEEP_SEC)) m_st = M_IDLE;
                end
            end
        endcase
    endfunction

    // One clock: drive inputs at negedge, compare every output, then advance the model.
    task automatic cyc(input bit s, input bit sp, input bit a, input bit d, input logic [1:0] m);
        @(negedge clk);
        bus.start = s; bus.stop = sp; bus.time_add = a; bus.door_open = d; bus.mode = m;
        #1;
        last_mag  = bus.magnetron_en;
        last_beep = bus.beep;
        check_val("idle",      32'(bus.idle),      int'(m_st == M_IDLE));
        check_val("cooking",   32'(bus.cooking),   int'(m_st == M_COOK));
        check_val("beep",      32'(bus.beep),      int'(m_st == M_DONE));
        check_val("remaining", 32'(bus.remaining), m_rem);
        check_val("magnetron", 32'(bus.magnetron_en),
                  int'(m_st == M_COOK && !d && m_win < m_on));
        @(posedge clk);
        model_step(s, sp, a, d, m);
    endtask

    task automatic idle_cycles(input int n, input logic [1:0] m);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, m);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int guard;
        bit rd;
        bit rs, rsp, ra;
        logic [1:0] rm;

        rst = 1'b0;
        bus.start = 0; bus.stop = 0; bus.time_add = 0; bus.door_open = 0; bus.mode = 2'b10;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_idle", 32'(bus.idle), 1);
        check_val("rst_rem",  32'(bus.remaining), 0);
        check_val("rst_mag",  32'(bus.magnetron_en), 0);
        rst = 1'b1;

        // 1: async reset mid-cook, then quick start
        cyc(0, 0, 1, 0, 2'b10);
        cyc(1, 0, 0, 0, 2'b10);
        guard = 0;
        while (m_rem != 17 && guard < 500) begin idle_cycles(1, 2'b10); guard++; end
        check_val("reach_17", 32'(m_rem == 17), 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_val("arst_idle", 32'(bus.idle), 1);
        check_val("arst_rem",  32'(bus.remaining), 0);
        check_val("arst_mag",  32'(bus.magnetron_en), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cyc(1, 0, 0, 0, 2'b10);
        #1 check_val("quick_start_rem", 32'(bus.remaining), 30);
        cyc(0, 1, 0, 0, 2'b10);
        cyc(0, 1, 0, 0, 2'b10);

        // 2: low power duty 3/10
        cyc(0, 0, 1, 0, 2'b01);
        cyc(1, 0, 0, 0, 2'b01);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin cyc(0, 0, 0, 0, 2'b01); cnt += int'(last_mag); end
        check_val("duty_low", 32'(cnt), 12);
        cyc(0, 1, 0, 0, 2'b01);
        cyc(0, 1, 0, 0, 2'b01);

        // 3: high power to completion, then beep
        cyc(0, 0, 1, 0, 2'b11);
        cyc(1, 0, 0, 0, 2'b11);
        cnt = 0; guard = 0;
        while (m_st != M_DONE && guard < 200) begin
            cyc(0, 0, 0, 0, 2'b11); cnt += int'(!last_mag); guard++;
        end
        check_val("high_gaps", 32'(cnt), 0);
        cnt = 0; guard = 0;
        while (m_st == M_DONE && guard < 50) begin
            cyc(0, 0, 0, 0, 2'b11); cnt += int'(last_beep); guard++;
        end
        check_val("beep_len", 32'(cnt), 12);

        // 4: door interlock and resume
        cyc(0, 0, 1, 0, 2'b10);
        cyc(1, 0, 0, 0, 2'b10);
        guard = 0;
        while (m_rem != 20 && guard < 200) begin idle_cycles(1, 2'b10); guard++; end
        cyc(0, 0, 0, 1, 2'b10);
        check_val("door_mag", 32'(last_mag), 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 2'b10);
        #1 check_val("door_hold_rem", 32'(bus.remaining), 20);
        check_val("door_paused", 32'(bus.cooking), 0);
        cyc(0, 0, 0, 0, 2'b10);
        cyc(1, 0, 0, 0, 2'b10);
        idle_cycles(9, 2'b10);
        cyc(0, 1, 0, 0, 2'b10);
        cyc(0, 1, 0, 0, 2'b10);

        // 5: saturation and start+stop collision
        for (int i = 0; i < 40; i++) cyc(0, 0, 1, 0, 2'b10);
        #1 check_val("sat_rem", 32'(bus.remaining), 999);
        cyc(1, 1, 0, 0, 2'b10);
        #1 check_val("collide_rem", 32'(bus.remaining), 0);
        check_val("collide_idle", 32'(bus.idle), 1);

        // 6: mode change mid-cook ignored, stop twice cancels
        cyc(0, 0, 1, 0, 2'b10);
        cyc(1, 0, 0, 0, 2'b10);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin cyc(0, 0, 0, 0, 2'b01); cnt += int'(last_mag); end
        check_val("duty_latched", 32'(cnt), 24);
        cyc(0, 1, 0, 0, 2'b01);
        #1 check_val("stop1_idle", 32'(bus.idle), 0);
        cyc(0, 1, 0, 0, 2'b01);
        #1 check_val("stop2_rem", 32'(bus.remaining), 0);
        check_val("stop2_idle", 32'(bus.idle), 1);

        // Random panel activity
        rd = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 2) rd = !rd;
            rs  = ($urandom_range(99) < 8);
            rsp = ($urandom_range(99) < 2);
            ra  = ($urandom_range(99) < 6);
            rm  = 2'($urandom_range(3));
            cyc(rs, rsp, ra, rd, rm);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/microwave_cook_ctrl.md
Name: microwave_cook_ctrl

Overview:
- Cook-cycle sequencer for the microwave: holds the cook time, counts it down in seconds, and drives the magnetron enable at a duty cycle set by the power mode.
- Takes the 2-bit mode from the mode-select block and feeds back `idle`, which gates mode changes.
- Handles door interlock, pause/resume, cancel and the end-of-cook beep.

Parameters:
- CLK_DIV, 100000000, clk cycles per 1-second tick (bench uses 4).
- TIME_W, 10, width of the remaining-seconds counter.
- ADD_SEC, 30, seconds added per time_add pulse (also the quick-start load).
- MAX_SEC, 999, saturation limit for remaining time.
- BEEP_SEC, 3, seconds the beep output stays high in DONE.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- start  input  1  start/resume request, single-cycle pulse
- stop  input  1  pause/cancel request, single-cycle pulse
- time_add  input  1  add ADD_SEC to cook time, single-cycle pulse
- door_open  input  1  door switch level, 1 = open
- mode  input  2  01 low, 10 normal, 11 high; 00 is treated as normal
- idle  output  1  high only in IDLE; feeds mode select
- cooking  output  1  high only in COOK
- magnetron_en  output  1  magnetron drive
- beep  output  1  end-of-cook beeper
- remaining  output  TIME_W  seconds left

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, remaining=0, prescaler=0, win_cnt=0, beep_cnt=0, latched mode=normal.
  - idle=1; cooking, magnetron_en and beep all 0.
- States: IDLE, COOK, PAUSE, DONE. All transitions are registered and take effect on the next clk edge.
- Input priority each cycle: door_open > stop > start > time_add.
- Tick:
  - Prescaler counts 0..CLK_DIV-1, and only in COOK or DONE.
  - The tick fires in the cycle the prescaler is at CLK_DIV-1; the prescaler then wraps to 0.
  - In PAUSE the prescaler holds its value; entering COOK from IDLE clears it to 0.
- time_add:
  - Honoured in IDLE, COOK and PAUSE.
  - remaining = min(remaining+ADD_SEC, MAX_SEC), computed at TIME_W+1 bits and then saturated.
- IDLE:
  - stop: remaining cleared to 0.
  - start with door closed and remaining>0: go to COOK, latch mode, clear win_cnt and prescaler.
  - start with door closed and remaining==0 (quick start): remaining=ADD_SEC, then as above.
  - start with door open is ignored.
- COOK:
  - On each tick: remaining decrements and win_cnt increments 0..9, wrapping to 0.
  - Decrement from 1 to 0 moves to DONE on the same edge, with beep_cnt=0.
  - door_open or stop: go to PAUSE, remaining unchanged.
  - A tick coinciding with door_open/stop is dropped; remaining does not decrement.
- PAUSE:
  - start with door closed: back to COOK; win_cnt and prescaler resume from held values.
  - stop: go to IDLE with remaining=0.
  - start with door open is ignored.
- DONE:
  - beep=1.
  - Each tick increments beep_cnt; at the tick that makes beep_cnt==BEEP_SEC, go to IDLE.
  - start or stop goes to IDLE immediately. door_open has no effect.
- Duty:
  - Latched mode gives an on-window: low=3, normal=6, high=10 (of 10 s).
  - magnetron_en = (state==COOK) & ~door_open & (win_cnt < on-window). The door_open term is combinational so the magnetron drops in the same cycle the door opens.
- Mode: latched only on IDLE→COOK. Changes on `mode` during COOK or PAUSE are ignored.
- Outputs idle, cooking, beep and remaining are registered or decoded from state only; magnetron_en is the only output with a combinational term.

Test Plan (CLK_DIV=4, ADD_SEC=30, MAX_SEC=999, BEEP_SEC=3):
1. rst low mid-COOK with remaining=17 → same cycle: idle=1, remaining=0, magnetron_en=0; after release, start → quick start with remaining=30.
2. mode=01, time_add ×1, start → remaining counts 30,29,… every 4 clk; magnetron_en high for the first 3 ticks of each 10-tick window, then low for 7.
3. mode=11, cook to 0 → magnetron_en always high; at remaining 1→0 go to DONE, beep=1 for 12 clk, then idle=1.
4. COOK at remaining=20, door_open=1 → magnetron_en=0 same cycle, state PAUSE, remaining stays 20; start with door open ignored; door closed + start → COOK, countdown resumes.
5. time_add ×40 in IDLE → remaining saturates at 999. Simultaneous start+stop in IDLE → stop wins, remaining=0, stays IDLE.
6. COOK with mode=10, change mode to 01 mid-cook → duty stays 6/10; stop, stop → PAUSE then IDLE with remaining=0.
